// File: rtl/baud_tick_scheduler_if.sv
// Config handshake, tick requests and tick/status outputs of the baud tick scheduler.
interface baud_tick_scheduler_if #(
    parameter int unsigned DIV_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;
    logic             tx_req;
    logic             rx_req;
    logic             os_tick;
    logic             tx_tick;
    logic             busy;
    logic [DIV_W-1:0] cur_div;

    // Requester side: issues config and tick requests, consumes ticks.
    modport master (
        output cfg_valid, cfg_div, cfg_en, tx_req, rx_req,
        input  cfg_ready, os_tick, tx_tick, busy, cur_div
    );

    // Scheduler side.
    modport slave (
        input  cfg_valid, cfg_div, cfg_en, tx_req, rx_req,
        output cfg_ready, os_tick, tx_tick, busy, cur_div
    );
endinterface

// File: rtl/baud_tick_scheduler.sv
// Baud tick scheduler: runtime divisor/enable, oversample and bit ticks,
// divisor changes deferred to the next bit boundary.
module baud_tick_scheduler #(
    parameter int unsigned CLK_IN      = 100_000_000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = CLK_IN / (115200 * OVERSAMPLE)
) (
    input  logic                 clk_in,
    input  logic                 reset,
    baud_tick_scheduler_if.slave bus
);
    localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           st_q, st_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_en_q, pend_en_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic [OS_W-1:0]  os_q, os_d;
    logic             os_tick_q, os_tick_d;
    logic             tx_tick_q, tx_tick_d;

    logic             xfer;
    logic             req;
    logic             os_fire;
    logic             bit_fire;
    logic [DIV_W-1:0] div_clamped;

    assign bus.cfg_ready = ~reset && (st_q != ST_DRAIN);
    assign xfer          = bus.cfg_valid && bus.cfg_ready;
    assign req           = bus.tx_req || bus.rx_req;
    assign div_clamped   = (bus.cfg_div < DIV_MIN) ? DIV_MIN : bus.cfg_div;
    assign os_fire       = (pre_q == (div_q - DIV_W'(1)));
    assign bit_fire      = os_fire && (os_q == OS_W'(OVERSAMPLE - 1));

    assign bus.os_tick = os_tick_q;
    assign bus.tx_tick = tx_tick_q;
    assign bus.busy    = (st_q != ST_IDLE);
    assign bus.cur_div = div_q;

    // Next-state, counter and tick logic.
    always_comb begin
        st_d       = st_q;
        div_d      = div_q;
        en_d       = en_q;
        pend_div_d = pend_div_q;
        pend_en_d  = pend_en_q;
        pre_d      = pre_q;
        os_d       = os_q;
        os_tick_d  = 1'b0;
        tx_tick_d  = 1'b0;
        case (st_q)
            ST_IDLE: begin
                pre_d = '0;
                os_d  = '0;
                // A config accepted here decides RUN entry on the next cycle.
                if (xfer) begin
                    div_d = div_clamped;
                    en_d  = bus.cfg_en;
                end else if (en_q && req) begin
                    st_d = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (!req) begin
                    // Requests gone: stop, apply any pending or arriving config.
                    st_d  = ST_IDLE;
                    pre_d = '0;
                    os_d  = '0;
                    if (st_q == ST_DRAIN) begin
                        div_d = pend_div_q;
                        en_d  = pend_en_q;
                    end else if (xfer) begin
                        div_d = div_clamped;
                        en_d  = bus.cfg_en;
                    end
                end else begin
                    pre_d     = os_fire ? '0 : pre_q + DIV_W'(1);
                    os_d      = os_fire ? (bit_fire ? '0 : os_q + OS_W'(1)) : os_q;
                    os_tick_d = os_fire;
                    tx_tick_d = bit_fire;
                    if (st_q == ST_DRAIN) begin
                        // Bit boundary: switch to the pending divisor.
                        if (bit_fire) begin
                            div_d = pend_div_q;
                            en_d  = pend_en_q;
                            st_d  = pend_en_q ? ST_RUN : ST_IDLE;
                        end
                    end else if (xfer) begin
                        pend_div_d = div_clamped;
                        pend_en_d  = bus.cfg_en;
                        st_d       = ST_DRAIN;
                    end
                end
            end
            default: begin
                st_d  = ST_IDLE;
                pre_d = '0;
                os_d  = '0;
            end
        endcase
    end

    // State, config and tick registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            st_q       <= ST_IDLE;
            div_q      <= DIV_W'(DEFAULT_DIV);
            en_q       <= 1'b0;
            pend_div_q <= '0;
            pend_en_q  <= 1'b0;
            pre_q      <= '0;
            os_q       <= '0;
            os_tick_q  <= 1'b0;
            tx_tick_q  <= 1'b0;
        end else begin
            st_q       <= st_d;
            div_q      <= div_d;
            en_q       <= en_d;
            pend_div_q <= pend_div_d;
            pend_en_q  <= pend_en_d;
            pre_q      <= pre_d;
            os_q       <= os_d;
            os_tick_q  <= os_tick_d;
            tx_tick_q  <= tx_tick_d;
        end
    end
endmodule

// File: tb/tb_baud_tick_scheduler.sv
// Bench for baud_tick_scheduler: directed scenarios plus random traffic
// checked every cycle against a phase-arithmetic reference model.
module tb_baud_tick_scheduler;
    localparam int unsigned DIV_W = 16;
    localparam int          OS    = 16;
    localparam int          DEF   = 54;

    logic clk_in;
    logic reset;
    int   total;
    int   bad;

    baud_tick_scheduler_if #(.DIV_W(DIV_W)) bus ();

    baud_tick_scheduler #(.DIV_W(DIV_W)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, required finish before 2000000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 run, 2 drain; ticks derived from the
    // number of ticking cycles since RUN entry or the last apply.
    int m_mode, m_div, m_en, m_pdiv, m_pen, m_elapsed, m_cl;
    bit m_os, m_tx, m_valid, m_xfer, m_req;

    initial begin
        m_valid = 1'b0;
        m_mode = 0; m_div = DEF; m_en = 0; m_pdiv = 0; m_pen = 0; m_elapsed = 0;
        m_os = 1'b0; m_tx = 1'b0;
        forever begin
            @(negedge clk_in);
            if (m_valid) begin
                chk("os_tick",   32'(bus.os_tick),   32'(m_os));
                chk("tx_tick",   32'(bus.tx_tick),   32'(m_tx));
                chk("busy",      32'(bus.busy),      32'(m_mode != 0));
                chk("cur_div",   32'(bus.cur_div),   32'(m_div));
                chk("cfg_ready", 32'(bus.cfg_ready), 32'(!reset && m_mode != 2));
            end
            if (reset) begin
                m_valid = 1'b1;
                m_mode = 0; m_div = DEF; m_en = 0; m_pdiv = 0; m_pen = 0; m_elapsed = 0;
                m_os = 1'b0; m_tx = 1'b0;
            end else if (m_valid) begin
                m_xfer = bus.cfg_valid && (m_mode != 2);
                m_req  = bus.tx_req || bus.rx_req;
                m_cl   = (int'(bus.cfg_div) < 2) ? 2 : int'(bus.cfg_div);
                m_os   = 1'b0;
                m_tx   = 1'b0;
                if (m_mode == 0) begin
                    if (m_xfer) begin
                        m_div = m_cl; m_en = int'(bus.cfg_en);
                    end else if (m_en != 0 && m_req) begin
                        m_mode = 1; m_elapsed = 0;
                    end
                end else if (!m_req) begin
                    if (m_mode == 2) begin
                        m_div = m_pdiv; m_en = m_pen;
                    end else if (m_xfer) begin
                        m_div = m_cl; m_en = int'(bus.cfg_en);
                    end
                    m_mode = 0;
                end else begin
                    m_elapsed++;
                    m_os = (m_elapsed % m_div) == 0;
                    m_tx = (m_elapsed % (m_div * OS)) == 0;
                    if (m_mode == 2) begin
                        if (m_tx) begin
                            m_div = m_pdiv; m_en = m_pen;
                            m_mode = (m_pen != 0) ? 1 : 0;
                            m_elapsed = 0;
                        end
                    end else if (m_xfer) begin
                        m_pdiv = m_cl; m_pen = int'(bus.cfg_en); m_mode = 2;
                    end
                end
            end
        end
    end

    task automatic step_cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Edges until the chosen tick is seen; -1 if the bound expires.
    task automatic edges_until(input bit want_tx, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk_in);
            #1;
            if (want_tx ? bus.tx_tick : bus.os_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_os(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin
            @(posedge clk_in);
            #1;
            if (bus.os_tick) c++;
        end
    endtask

    task automatic send_cfg(input int div, input bit en);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = DIV_W'(div);
        bus.cfg_en    = en;
        step_cyc(1);
        bus.cfg_valid = 1'b0;
    endtask

    int n;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.cfg_en    = 1'b0;
        bus.tx_req    = 1'b1;
        bus.rx_req    = 1'b0;

        // Reset with a request pending: defaults, no ticks.
        step_cyc(3);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.cfg_ready), 32'd1);
        chk("rst_div",   32'(bus.cur_div),   32'd54);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        count_os(10, n);
        chk("rst_no_ticks", 32'(n), 32'd0);

        // Basic ticking with divisor 4.
        bus.tx_req = 1'b0;
        send_cfg(4, 1'b1);
        chk("idle_cfg_div", 32'(bus.cur_div), 32'd4);
        bus.rx_req = 1'b1;
        edges_until(1'b0, 50, n);
        chk("first_os", 32'(n), 32'd5);
        chk("run_busy", 32'(bus.busy), 32'd1);
        edges_until(1'b0, 50, n);
        chk("os_gap4", 32'(n), 32'd4);
        edges_until(1'b1, 200, n);
        chk("first_tx", 32'(n), 32'd56);
        chk("tx_with_os", 32'(bus.os_tick), 32'd1);

        // Deferred change to 6 mid-bit.
        step_cyc(2);
        send_cfg(6, 1'b1);
        chk("drain_ready", 32'(bus.cfg_ready), 32'd0);
        chk("drain_div",   32'(bus.cur_div),   32'd4);
        edges_until(1'b1, 200, n);
        chk("apply_tx", 32'(n), 32'd61);
        chk("apply_div", 32'(bus.cur_div), 32'd6);
        edges_until(1'b0, 50, n);
        chk("os_gap6", 32'(n), 32'd6);
        chk("run_ready", 32'(bus.cfg_ready), 32'd1);

        // Drain aborted by dropping requests.
        send_cfg(9, 1'b1);
        bus.rx_req = 1'b0;
        step_cyc(1);
        chk("abort_div",  32'(bus.cur_div), 32'd9);
        chk("abort_busy", 32'(bus.busy),    32'd0);
        count_os(30, n);
        chk("abort_quiet", 32'(n), 32'd0);

        // Clamp, then disable while running.
        send_cfg(0, 1'b1);
        chk("clamp_div", 32'(bus.cur_div), 32'd2);
        bus.tx_req = 1'b1;
        edges_until(1'b0, 20, n);
        chk("clamp_first_os", 32'(n), 32'd3);
        send_cfg(3, 1'b0);
        edges_until(1'b1, 100, n);
        chk("disable_tx", 32'(n), 32'd29);
        chk("disable_busy", 32'(bus.busy), 32'd0);
        chk("disable_div", 32'(bus.cur_div), 32'd3);
        count_os(40, n);
        chk("disable_quiet", 32'(n), 32'd0);

        // Transfer and request rising together.
        bus.tx_req = 1'b0;
        step_cyc(1);
        bus.tx_req = 1'b1;
        send_cfg(5, 1'b1);
        edges_until(1'b0, 30, n);
        chk("simul_first_os", 32'(n), 32'd6);

        // Reset while draining discards the pending config.
        send_cfg(7, 1'b1);
        reset = 1'b1;
        step_cyc(1);
        chk("rst_drain_div",   32'(bus.cur_div),   32'd54);
        chk("rst_drain_busy",  32'(bus.busy),      32'd0);
        chk("rst_drain_ready", 32'(bus.cfg_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_rel_ready", 32'(bus.cfg_ready), 32'd1);
        count_os(20, n);
        chk("rst_quiet", 32'(n), 32'd0);
        chk("rst_keep_div", 32'(bus.cur_div), 32'd54);

        // Random traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            bus.cfg_valid = ($urandom_range(0, 9) == 0);
            bus.cfg_div   = DIV_W'($urandom_range(0, 9));
            bus.cfg_en    = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 59) == 0) bus.tx_req = ~bus.tx_req;
            if ($urandom_range(0, 59) == 0) bus.rx_req = ~bus.rx_req;
            reset = ($urandom_range(0, 1999) == 0);
            step_cyc(1);
        end
        reset = 1'b0;
        bus.cfg_valid = 1'b0;
        step_cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/baud_tick_scheduler.md
# baud_tick_scheduler

Runtime-configurable baud tick generator and controller for the UART. It holds the active divisor and enable in registers and produces a 1-cycle oversample tick and a 1-cycle bit tick for the TX and RX engines. Ticks run only while the divider is enabled and at least one engine requests them. Divisor changes arriving mid-frame are deferred to the next bit boundary so a running bit is never stretched or truncated.

## Interface
- `CLK_IN`, 100_000_000: input clock frequency (Hz), used only for `DEFAULT_DIV`.
- `OVERSAMPLE`, 16: oversample ticks per bit tick, ≥ 2.
- `DIV_W`, 16: divisor width.
- `DEFAULT_DIV`, `CLK_IN/(115200*OVERSAMPLE)` (= 54): divisor loaded at reset.

- `clk_in`, input, 1: single clock, all logic on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `cfg_valid`, input, 1: config request.
- `cfg_ready`, output, 1: config can be accepted.
- `cfg_div`, input, `DIV_W`: requested divisor (clk_in cycles per oversample tick).
- `cfg_en`, input, 1: requested enable.
- `tx_req`, input, 1: TX engine needs ticks (level).
- `rx_req`, input, 1: RX engine needs ticks (level).
- `os_tick`, output, 1: oversample tick, 1-cycle pulse.
- `tx_tick`, output, 1: bit tick, 1-cycle pulse coincident with every `OVERSAMPLE`-th `os_tick`.
- `busy`, output, 1: high when the state is not IDLE.
- `cur_div`, output, `DIV_W`: active divisor register `div_q`.

## Operation
- **Registers**
  - `div_q` and `en_q` (active config).
  - `pend_div` and `pend_en` (pending config).
  - `pre_cnt` counts 0..`div_q`-1.
  - `os_cnt` counts 0..`OVERSAMPLE`-1.
  - State is one of IDLE, RUN, DRAIN.
- **Clamping:** any `cfg_div` < 2 is stored as 2.
- **Handshake:** a transfer occurs when `cfg_valid & cfg_ready`.
  - `cfg_ready` = 1 in IDLE and RUN.
  - `cfg_ready` = 0 in DRAIN and during reset.
- **IDLE**
  - Counters are held at 0; no ticks.
  - A transfer loads `div_q`/`en_q` at that edge.
  - Go to RUN when `en_q & (tx_req | rx_req)`, evaluated using the registered `en_q`.
  - A transfer and a request rise in the same cycle: the config is applied first, and RUN entry is decided the next cycle using the new `en_q`.
- **RUN**
  - `pre_cnt` increments each cycle. On `pre_cnt == div_q-1`: wrap to 0, pulse `os_tick`, and increment `os_cnt`.
  - On `os_cnt == OVERSAMPLE-1` with `os_tick`: wrap `os_cnt` and pulse `tx_tick`.
  - `tx_req` and `rx_req` both low → IDLE, counters cleared.
  - A transfer → latch `pend_*` and go to DRAIN. Ticks continue with the old `div_q`.
  - If the requests drop in the same cycle as a transfer, go to IDLE with the config applied directly.
- **DRAIN**
  - Ticks continue on the old divisor.
  - Apply point: the cycle `tx_tick` is asserted, or the cycle both requests are low, whichever comes first.
  - At the apply point: load `div_q`/`en_q` from `pend_*` and clear both counters.
  - Next state is RUN if the new `en_q` is set and requests are present, else IDLE.
- **`en_q` = 0 in RUN:** only reachable via apply, and the apply itself goes to IDLE.

## Timing
- **Reset values:**
  - state IDLE; `div_q` = `DEFAULT_DIV`; `en_q` = 0; counters 0.
  - `os_tick` = 0; `tx_tick` = 0; `busy` = 0; `cur_div` = `DEFAULT_DIV`.
  - `cfg_ready` = 0 during reset, 1 the cycle after.
- **Reset mid-operation:** discards pending config and ticks immediately at that edge.
- **Output registration:** `os_tick` and `tx_tick` are registered.
  - First `os_tick` appears exactly `div_q` cycles after the first RUN cycle.
  - Subsequent `os_tick` pulses are spaced `div_q` cycles apart.
  - `tx_tick` period is `div_q*OVERSAMPLE`.
- **After apply:** the first `os_tick` on the new divisor comes new `div_q` cycles after the apply edge. No partial tick is issued.
- **`cur_div` / `busy`:** change on the apply/transfer edge, never between ticks.
- **Config latency:**
  - IDLE: 1 edge.
  - RUN: ≤ `div_q_old*OVERSAMPLE` cycles.

## Test plan
1. **Reset/defaults:** assert `reset` for 3 cycles, with `tx_req`=1 → `cur_div`=54, no ticks, `busy`=0, `cfg_ready`=1 after release.
2. **Basic ticking:** in IDLE, transfer `cfg_div`=4, `cfg_en`=1; raise `rx_req` → `os_tick` every 4 cycles (first at RUN+4), `tx_tick` every 64 cycles, `busy`=1.
3. **Deferred change:** in RUN with div 4, transfer `cfg_div`=6 mid-bit → `cfg_ready`=0, `os_tick` spacing stays 4 until `tx_tick`, then spacing is 6 and `cur_div`=6 from that edge.
4. **Drain abort:** in DRAIN, drop `tx_req`/`rx_req` → config applied the same edge, IDLE, no further ticks, `cur_div` = new value.
5. **Clamp and disable:** transfer `cfg_div`=0 → `cur_div`=2. Transfer `cfg_en`=0 while running → after the bit boundary, IDLE and ticks stop despite `tx_req`=1.
6. **Simultaneous/reset:**
   - Transfer in IDLE the same cycle `tx_req` rises → first `os_tick` at new `div_q`+1 cycles.
   - `reset` in DRAIN → pending discarded, `cur_div`=54.
